sseg_display_arbiter: RTL and testbench

//  Shares the 4-digit seven-segment display between NUM_REQ requesters (rover status sources).

---
 rtl/sseg_display_arbiter.sv | 131 +++++++++++++
 tb/tb_sseg_display_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sseg_display_arbiter.sv
// Round-robin owner of the 4-digit display with minimum hold, plus free-running digit scan.
// Grant is registered one edge after a request is seen; digit/an are combinational from flops.
module sseg_display_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int SCAN_DIV    = 50000,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  data,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic [3:0]             digit,
  output logic [3:0]             an
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [PW:0]   NREQ_W    = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0] PTR_RST   = PW'(NUM_REQ - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [15:0]          shadow_q, shadow_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [SW-1:0]        scan_q, scan_d;
  logic [1:0]           idx_q, idx_d;

  logic [15:0]          data_arr [NUM_REQ];
  logic                 pick_vld;
  logic [PW-1:0]        pick_idx;
  logic [PW:0]          cand;
  logic [PW-1:0]        cand_idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_data
    assign data_arr[i] = data[16*i +: 16];
  end

  // First pending request after ptr, wrapping so ptr itself is considered last.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr_q;
    cand     = '0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      cand_idx = cand[PW-1:0];
      if (!pick_vld && req[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    shadow_d = shadow_q;
    grant_d  = '0;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (pick_vld) begin
          state_d = GRANT;
          ptr_d   = pick_idx;
        end
      end
      GRANT: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (pick_vld) ptr_d = pick_idx;
          else          state_d = IDLE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Shadow follows the owner that will hold the display after this edge.
    if (state_d == IDLE) begin
      shadow_d = 16'hFFFF;
    end else begin
      grant_d[ptr_d] = 1'b1;
      if (req[ptr_d]) shadow_d = data_arr[ptr_d];
    end
  end

  always_comb begin
    scan_d = scan_q + SW'(1);
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= PTR_RST;
      hold_q   <= '0;
      shadow_q <= 16'hFFFF;
      grant_q  <= '0;
      scan_q   <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      shadow_q <= shadow_d;
      grant_q  <= grant_d;
      scan_q   <= scan_d;
      idx_q    <= idx_d;
    end
  end

  assign grant = grant_q;
  assign busy  = |grant_q;
  assign an    = ~(4'b0001 << idx_q);
  assign digit = shadow_q[{idx_q, 2'b00} +: 4];

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Directed bench for sseg_display_arbiter with a cycle-level reference model.
module tb_sseg_display_arbiter;

  localparam int NUM_REQ = 3;
  localparam int SCAN    = 4;
  localparam int HOLD    = 8;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] data;
  logic [NUM_REQ-1:0]    grant;
  logic                  busy;
  logic [3:0]            digit;
  logic [3:0]            an;

  int n_tests = 0;
  int n_fail  = 0;

  sseg_display_arbiter #(
    .NUM_REQ(NUM_REQ), .SCAN_DIV(SCAN), .HOLD_CYCLES(HOLD)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .data(data),
    .grant(grant), .busy(busy), .digit(digit), .an(an)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner (-1 = idle), cycles served, last pointer, shown value, edges since reset.
  int          m_owner  = -1;
  int          m_ptr    = NUM_REQ - 1;
  int          m_age    = 0;
  logic [15:0] m_shadow = 16'hFFFF;
  longint      m_ticks  = 0;

  function automatic int rr_pick(input int p);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (req[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  int          t_owner, t_ptr, t_age, t_nxt;
  logic [15:0] t_shadow;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_owner  <= -1;
      m_ptr    <= NUM_REQ - 1;
      m_age    <= 0;
      m_shadow <= 16'hFFFF;
      m_ticks  <= 0;
    end else begin
      t_owner  = m_owner;
      t_ptr    = m_ptr;
      t_age    = m_age;
      t_shadow = m_shadow;
      if (t_owner < 0) begin
        t_nxt = rr_pick(t_ptr);
        if (t_nxt >= 0) begin
          t_owner = t_nxt;
          t_ptr   = t_nxt;
          t_age   = 0;
        end
      end else begin
        t_age = t_age + 1;
        if (t_age == HOLD) begin
          t_nxt   = rr_pick(t_owner);
          t_age   = 0;
          t_owner = t_nxt;
          if (t_nxt >= 0) t_ptr = t_nxt;
        end
      end
      if (t_owner < 0) t_shadow = 16'hFFFF;
      else if (req[t_owner]) t_shadow = data[16*t_owner +: 16];
      m_owner  <= t_owner;
      m_ptr    <= t_ptr;
      m_age    <= t_age;
      m_shadow <= t_shadow;
      m_ticks  <= m_ticks + 1;
    end
  end

  logic [NUM_REQ-1:0] e_grant;
  logic [3:0]         e_an, e_digit;
  int                 e_idx;

  always @(negedge clock) begin
    e_idx   = int'((m_ticks / SCAN) % 4);
    e_grant = '0;
    if (m_owner >= 0) e_grant[m_owner] = 1'b1;
    e_an    = ~(4'b0001 << e_idx);
    e_digit = m_shadow[4*e_idx +: 4];
    chk("model_grant", 32'(grant), 32'(e_grant));
    chk("model_busy",  32'(busy),  32'(m_owner >= 0));
    chk("model_an",    32'(an),    32'(e_an));
    chk("model_digit", 32'(digit), 32'(e_digit));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Called at posedge+1: reset asserts between edges and outputs must already be at reset values.
  task automatic do_reset(input logic [NUM_REQ-1:0] r);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_an",    32'(an),    32'hE);
    chk("rst_digit", 32'(digit), 32'hF);
    tick(1);
    reset_n = 1'b1;
    req     = r;
  endtask

  logic [NUM_REQ-1:0] exp_g;

  initial begin
    reset_n = 1'b0;
    req     = '0;
    data    = '0;
    tick(2);

    // Single requester: scan walk and digit order.
    data[15:0] = 16'h1234;
    do_reset(3'b001);
    tick(1);
    chk("t2_grant", 32'(grant), 32'h1);
    chk("t2_an0",   32'(an),    32'hE);
    chk("t2_dig0",  32'(digit), 32'h4);
    tick(3);
    chk("t2_an1",   32'(an),    32'hD);
    chk("t2_dig1",  32'(digit), 32'h3);
    tick(4);
    chk("t2_an2",   32'(an),    32'hB);
    chk("t2_dig2",  32'(digit), 32'h2);
    tick(4);
    chk("t2_an3",   32'(an),    32'h7);
    chk("t2_dig3",  32'(digit), 32'h1);
    tick(4);
    chk("t2_an_wrap",  32'(an),    32'hE);
    chk("t2_dig_wrap", 32'(digit), 32'h4);
    chk("t2_stay",     32'(grant), 32'h1);

    // Round-robin with all requesters active, no idle gap.
    data = {16'h5678, 16'hABCD, 16'h1234};
    do_reset(3'b111);
    for (int t = 1; t <= 32; t++) begin
      tick(1);
      exp_g = (t <= 8) ? 3'b001 : (t <= 16) ? 3'b010 : (t <= 24) ? 3'b100 : 3'b001;
      chk("t3_grant", 32'(grant), 32'(exp_g));
      chk("t3_busy",  32'(busy),  32'h1);
    end

    // Early drop: value freezes, grant held to hold expiry, then idle.
    data = {16'h0000, 16'h0000, 16'h1234};
    do_reset(3'b001);
    tick(4);
    req        = 3'b000;
    data[15:0] = 16'h9999;
    tick(1);
    chk("t4_frozen", 32'(digit), 32'h3);
    tick(3);
    chk("t4_held",   32'(grant), 32'h1);
    chk("t4_dig8",   32'(digit), 32'h2);
    tick(1);
    chk("t4_idle",   32'(grant), 32'h0);
    chk("t4_busy",   32'(busy),  32'h0);
    chk("t4_dash",   32'(digit), 32'hF);

    // Sole owner across several hold periods with a live data update.
    data = {16'h0000, 16'h0042, 16'h0000};
    do_reset(3'b010);
    for (int t = 1; t <= 40; t++) begin
      tick(1);
      chk("t5_grant", 32'(grant), 32'h2);
      if (t == 16) begin
        chk("t5_old", 32'(digit), 32'h2);
        data[31:16] = 16'h0043;
      end
      if (t == 17) chk("t5_new", 32'(digit), 32'h3);
    end

    // Reset in the middle of owner1's hold, then re-arbitrate from the reset pointer.
    do_reset(3'b010);
    tick(6);
    chk("t6_pre", 32'(grant), 32'h2);
    do_reset(3'b110);
    tick(1);
    chk("t6_first", 32'(grant), 32'h2);
    tick(8);
    chk("t6_next",  32'(grant), 32'h4);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
